// File: rtl/regfile_sb.sv
// regfile_sb: parametrised dual-read register file with PC register, busy scoreboard and optional write-through forwarding.
// Ports: CLK/RST (sync, active-high) clock and reset; RFE active-low enable (high freezes all state);
//   RA/RB -> A/B read data, BUSY_A/BUSY_B pending-result flags; WE/RC/DIN writeback; CE/RD clear;
//   ISSUE/RI mark busy; PC_LD/PC_IN load PC; PC_OUT current PC (register NREGS-1).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write/clear data and mask busy on writeback.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_INC = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RFE,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              BUSY_A,
  output logic              BUSY_B,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RC,
  input  logic [DATA_W-1:0] DIN,
  input  logic              CE,
  input  logic [ADDR_W-1:0] RD,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] RI,
  input  logic              PC_LD,
  input  logic [DATA_W-1:0] PC_IN,
  output logic [DATA_W-1:0] PC_OUT
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS-1);
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] regs_nx [NREGS];
  logic [NREGS-1:0] busy, busy_nx;
  // Later assignments override earlier ones, giving CE > WE > PC_LD > increment and issue over writeback-clear.
  always_comb begin
    regs_nx = regs;
    busy_nx = busy;
    regs_nx[PC_IDX] = PC_LD ? PC_IN : regs[PC_IDX] + DATA_W'(PC_INC);
    if (WE) begin
      regs_nx[RC] = DIN;
      busy_nx[RC] = 1'b0;
    end
    if (CE) regs_nx[RD] = '0;
    if (ISSUE) busy_nx[RI] = 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs <= '{default: '0};
      busy <= '0;
    end else if (!RFE) begin
      regs <= regs_nx;
      busy <= busy_nx;
    end
  end
  assign PC_OUT = regs[PC_IDX];
`ifdef REGFILE_BYPASS_EN
  logic clr_a, clr_b, wr_a, wr_b;
  assign clr_a = !RFE && CE && RD == RA;
  assign clr_b = !RFE && CE && RD == RB;
  assign wr_a = !RFE && WE && RC == RA;
  assign wr_b = !RFE && WE && RC == RB;
  assign A = clr_a ? '0 : wr_a ? DIN : regs[RA];
  assign B = clr_b ? '0 : wr_b ? DIN : regs[RB];
  assign BUSY_A = busy[RA] && !wr_a;
  assign BUSY_B = busy[RB] && !wr_b;
`else
  assign A = regs[RA];
  assign B = regs[RB];
  assign BUSY_A = busy[RA];
  assign BUSY_B = busy[RB];
`endif
endmodule
